// File: rtl/control_unit_pkg.sv
// Shared definitions for the multi-cycle arithmetic controller.
//   state_t        : FSM state encoding
//   op_t           : operation codes (add, sub, mul, div)
//   C_*            : bit positions inside the 8-bit datapath control word
//   ITERATIONS     : loop iterations per multiply/divide (one per operand bit)
//   cbit()         : builds a one-hot control-word mask from a bit position
package control_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_MUL_TEST,
    S_MUL_SHIFT,
    S_DIV_SHIFT,
    S_DIV_SUB,
    S_DIV_FIX,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  localparam int C_LOAD_A   = 0;  // A <= adder result
  localparam int C_SUB      = 1;  // adder subtracts
  localparam int C_LSHIFT   = 2;  // A:Q shift left
  localparam int C_RSHIFT   = 3;  // A:Q shift right
  localparam int C_LOAD_QM  = 4;  // Q <= x, M <= y
  localparam int C_CLR_A    = 5;  // A <= 0
  localparam int C_SET_Q0   = 6;  // Q[0] <= 1
  localparam int C_CNT_INCR = 7;  // iteration counter advances

  localparam int ITERATIONS = 8;
  localparam int CNT_W      = $clog2(ITERATIONS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERATIONS - 1);

  function automatic logic [7:0] cbit(input int unsigned idx);
    cbit = 8'd1 << idx;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Handshake and datapath-status bundle between the controller and its user.
//   start, op        : operation request (op sampled when start is accepted)
//   q0, a_b7, m_zero : datapath status bits fed back to the controller
//   c                : 8-bit datapath control word
//   busy, done, err  : controller status
// master = requester/datapath side, slave = controller side.
interface control_unit_if;

  logic       start;
  logic [1:0] op;
  logic       q0;
  logic       a_b7;
  logic       m_zero;
  logic [7:0] c;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, op, q0, a_b7, m_zero,
    input  c, busy, done, err
  );

  modport slave (
    input  start, op, q0, a_b7, m_zero,
    output c, busy, done, err
  );

endinterface

// File: rtl/control_unit_iter_cnt.sv
// iter_cnt: 3-bit loop iteration counter for multiply/divide.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (takes priority over incr)
//   incr     : advance by one, wrapping from the last value back to 0
//   last     : counter currently holds the final iteration value
module iter_cnt
  import control_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic incr,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  // Natural CNT_W-bit overflow provides the wrap to 0 on the final increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (incr) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CNT_LAST);

endmodule

// File: rtl/control_unit.sv
// control_unit: sequencing FSM for an 8-bit add/sub/mul/div datapath.
// Add/sub finish in one cycle; multiply runs unsigned shift-and-add and
// divide runs unsigned restoring division, each over eight iterations.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : control_unit_if.slave (start/op request, datapath status in,
//          control word c and busy/done/err out)
module control_unit
  import control_unit_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  control_unit_if.slave  bus
);

  state_t     state_q, state_d;
  op_t        op_q;
  logic       err_q;
  logic       accept;
  logic       set_err;
  logic       cnt_clr;
  logic       cnt_incr;
  logic       cnt_last;
  logic [7:0] ctl;

  assign accept = (state_q == S_IDLE) && bus.start;

  iter_cnt u_iter_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .incr (cnt_incr),
    .last (cnt_last)
  );

  // op is latched at acceptance so later changes on the bus are ignored.
  // err is cleared by the next accepted start, not by done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op_t'(bus.op);
        err_q <= 1'b0;
      end else if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ctl      = 8'h00;
    cnt_clr  = 1'b0;
    cnt_incr = 1'b0;
    set_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = bus.op[1] ? S_INIT : S_DONE;
        end
      end
      S_INIT: begin
        ctl     = cbit(C_LOAD_QM) | cbit(C_CLR_A);
        cnt_clr = 1'b1;
        if (op_q == OP_MUL) begin
          state_d = S_MUL_TEST;
        end else if (bus.m_zero) begin
          state_d = S_DONE;
          set_err = 1'b1;
        end else begin
          state_d = S_DIV_SHIFT;
        end
      end
      S_MUL_TEST: begin
        if (bus.q0) begin
          ctl = cbit(C_LOAD_A);
        end
        state_d = S_MUL_SHIFT;
      end
      S_MUL_SHIFT: begin
        ctl      = cbit(C_RSHIFT) | cbit(C_CNT_INCR);
        cnt_incr = 1'b1;
        state_d  = cnt_last ? S_DONE : S_MUL_TEST;
      end
      S_DIV_SHIFT: begin
        ctl     = cbit(C_LSHIFT);
        state_d = S_DIV_SUB;
      end
      S_DIV_SUB: begin
        ctl     = cbit(C_LOAD_A) | cbit(C_SUB);
        state_d = S_DIV_FIX;
      end
      S_DIV_FIX: begin
        // Negative trial remainder: add M back (restore), quotient bit stays 0.
        ctl      = cbit(C_CNT_INCR) | (bus.a_b7 ? cbit(C_LOAD_A) : cbit(C_SET_Q0));
        cnt_incr = 1'b1;
        state_d  = cnt_last ? S_DONE : S_DIV_SHIFT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.c    = ctl;
  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.err  = err_q;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: a behavioural A/Q/M datapath obeys the control
// word, and a scoreboard of expected latency/err/result is checked at done.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  control_unit_if bus();

  control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural datapath: C:A (9 bits), Q, M.
  logic [7:0] ma = 8'h00, mq = 8'h00, mm = 8'h00;
  logic       mc = 1'b0;
  logic [7:0] na, nq, nm;
  logic       nc;
  logic [8:0] sum;
  logic [7:0] xv = 8'h00, yv = 8'h00;

  assign bus.q0     = mq[0];
  assign bus.a_b7   = ma[7];
  assign bus.m_zero = (yv == 8'h00);

  always_comb begin
    na  = ma;
    nq  = mq;
    nm  = mm;
    nc  = mc;
    sum = 9'h000;
    if (bus.c[5]) begin
      na = 8'h00;
      nc = 1'b0;
    end
    if (bus.c[4]) begin
      nq = xv;
      nm = yv;
    end
    if (bus.c[0]) begin
      sum = bus.c[1] ? ({1'b0, ma} - {1'b0, mm}) : ({1'b0, ma} + {1'b0, mm});
      na  = sum[7:0];
      nc  = bus.c[1] ? 1'b0 : sum[8];
    end
    if (bus.c[3]) {nc, na, nq} = {1'b0, nc, na, nq[7:1]};
    if (bus.c[2]) {na, nq} = {na[6:0], nq, 1'b0};
    if (bus.c[6]) nq[0] = 1'b1;
  end

  always @(posedge clk) begin
    ma <= na;
    mq <= nq;
    mm <= nm;
    mc <= nc;
  end

  // Illegal control-word combinations are counted continuously.
  int viol = 0;
  always @(negedge clk) begin
    if ((bus.c[2] && bus.c[3]) || (bus.c[0] && bus.c[4])) viol = viol + 1;
  end

  typedef struct {
    int          lat;
    logic        err;
    logic        chk_z;
    logic [15:0] z;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int ncmp = 0;
  int nfail = 0;

  logic [7:0] tc [0:63];
  logic       tbusy [0:63];
  int         lat;

  // Request one operation, scramble op after acceptance, optionally pulse a
  // second start (op=11) at cycle inj, and record c/busy until done.
  task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        input int inj);
    @(negedge clk);
    xv = x;
    yv = y;
    bus.op = o;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op = ~o;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      tc[k] = bus.c;
      tbusy[k] = bus.busy;
      if (k == inj) begin
        bus.start = 1'b1;
        bus.op = 2'b11;
      end else if (k == inj + 1) begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic check_done(input string name);
    e = sb.pop_front();
    ncmp++;
    if (lat !== e.lat) begin
      nfail++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, e.lat);
    end
    ncmp++;
    if (bus.err !== e.err) begin
      nfail++;
      $display("FAIL %s err: got %b expected %b", name, bus.err, e.err);
    end
    if (e.chk_z) begin
      ncmp++;
      if ({ma, mq} !== e.z) begin
        nfail++;
        $display("FAIL %s result A:Q: got %h expected %h", name, {ma, mq}, e.z);
      end
    end
    @(negedge clk);
    ncmp++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      nfail++;
      $display("FAIL %s after done {done,busy}: got %b expected 00", name, {bus.done, bus.busy});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.op = 2'b10;
    #1;
    ncmp++;
    if ({bus.c, bus.busy, bus.done, bus.err} !== 11'h000) begin
      nfail++;
      $display("FAIL reset outputs: got c=%h busy=%b done=%b err=%b expected all 0",
               bus.c, bus.busy, bus.done, bus.err);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    ncmp++;
    if (bus.busy !== 1'b0) begin
      nfail++;
      $display("FAIL reset start ignored busy: got %b expected 0", bus.busy);
    end
    bus.start = 1'b0;
    bus.op = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_addsub(input logic [1:0] o, input string name);
    int nbusy;
    int nz;
    sb.push_back('{1, 1'b0, 1'b0, 16'h0000});
    run_op(o, 8'h12, 8'h34, 0);
    nbusy = 0;
    nz = 0;
    for (int k = 1; k <= 1; k++) begin
      if (tbusy[k]) nbusy++;
      if (tc[k] != 8'h00) nz++;
    end
    ncmp++;
    if (nbusy !== 1) begin
      nfail++;
      $display("FAIL %s busy cycles: got %0d expected 1", name, nbusy);
    end
    ncmp++;
    if (nz !== 0) begin
      nfail++;
      $display("FAIL %s nonzero c cycles: got %0d expected 0", name, nz);
    end
    check_done(name);
  endtask

  task automatic test_mul(input int inj, input string name);
    logic [7:0] c0_mask;
    int nshift;
    sb.push_back('{18, 1'b0, 1'b1, 16'h000F});
    run_op(2'b10, 8'h05, 8'h03, inj);
    c0_mask = 8'h00;
    nshift = 0;
    if (lat == 18) begin
      for (int i = 0; i < 8; i++) c0_mask[i] = tc[2 + 2 * i][0];
      for (int k = 1; k <= 18; k++) if (tc[k] == 8'h88) nshift++;
    end
    ncmp++;
    if (c0_mask !== 8'b0000_0101) begin
      nfail++;
      $display("FAIL %s MUL_TEST c0 pattern: got %b expected 00000101", name, c0_mask);
    end
    ncmp++;
    if (nshift !== 8) begin
      nfail++;
      $display("FAIL %s shift cycles: got %0d expected 8", name, nshift);
    end
    check_done(name);
  endtask

  task automatic test_div();
    logic [7:0] set_mask;
    int nl, ns;
    sb.push_back('{26, 1'b0, 1'b1, 16'h0103});
    run_op(2'b11, 8'h0D, 8'h04, 0);
    set_mask = 8'h00;
    nl = 0;
    ns = 0;
    if (lat == 26) begin
      for (int i = 0; i < 8; i++) set_mask[i] = (tc[4 + 3 * i] == 8'hC0);
      for (int k = 1; k <= 26; k++) begin
        if (tc[k] == 8'h04) nl++;
        if (tc[k] == 8'h03) ns++;
      end
    end
    ncmp++;
    if (set_mask !== 8'b1100_0000) begin
      nfail++;
      $display("FAIL div fix choices: got %b expected 11000000", set_mask);
    end
    ncmp++;
    if ({nl, ns} !== {32'd8, 32'd8}) begin
      nfail++;
      $display("FAIL div shift/sub cycles: got %0d/%0d expected 8/8", nl, ns);
    end
    check_done("div");
  endtask

  task automatic test_divzero();
    sb.push_back('{2, 1'b1, 1'b0, 16'h0000});
    run_op(2'b11, 8'h0D, 8'h00, 0);
    check_done("divzero");
    @(negedge clk);
    ncmp++;
    if (bus.err !== 1'b1) begin
      nfail++;
      $display("FAIL divzero err held: got %b expected 1", bus.err);
    end
    sb.push_back('{1, 1'b0, 1'b0, 16'h0000});
    run_op(2'b00, 8'h01, 8'h01, 0);
    check_done("err cleared on start");
  endtask

  task automatic test_reset_mid_div();
    int ndone;
    @(negedge clk);
    xv = 8'h0D;
    yv = 8'h04;
    bus.op = 2'b11;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    ncmp++;
    if ({bus.c, bus.busy, bus.done} !== 10'h000) begin
      nfail++;
      $display("FAIL mid-div reset: got c=%h busy=%b done=%b expected 0", bus.c, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.op = 2'b00;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    ncmp++;
    if (bus.done !== 1'b1) begin
      nfail++;
      $display("FAIL start after reset done: got %b expected 1", bus.done);
    end
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    ncmp++;
    if (ndone !== 0) begin
      nfail++;
      $display("FAIL stray done after reset: got %0d expected 0", ndone);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = 2'b00;
    test_reset();
    test_addsub(2'b00, "add");
    test_addsub(2'b01, "sub");
    test_mul(0, "mul");
    test_div();
    test_divzero();
    test_mul(5, "mul ignore start");
    test_reset_mid_div();
    ncmp++;
    if (viol !== 0) begin
      nfail++;
      $display("FAIL illegal control words: got %0d expected 0", viol);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
